// File: rtl/divider_pkg.sv
// Shared types, sizes and two's-complement helpers for the restoring divider.
package divider_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = 6;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CALC = 3'd1,
        FIX  = 3'd2,
        DONE = 3'd3,
        WAIT = 3'd4
    } div_state_t;

    function automatic logic [DIV_WIDTH-1:0] twos_neg(input logic [DIV_WIDTH-1:0] v);
        return ~v + {{(DIV_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Absolute value when the operand is interpreted as signed, identity otherwise.
    function automatic logic [DIV_WIDTH-1:0] magnitude(input logic [DIV_WIDTH-1:0] v,
                                                       input logic sgn);
        if (sgn && v[DIV_WIDTH-1]) begin
            return twos_neg(v);
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/divider_32bit_if.sv
// Request/result bundle between a divider client (master) and the divider (slave).
interface divider_32bit_if;

    logic                               div_begin;
    logic                               div_signed;
    logic [divider_pkg::DIV_WIDTH-1:0]  dividend;
    logic [divider_pkg::DIV_WIDTH-1:0]  divisor;
    logic [divider_pkg::DIV_WIDTH-1:0]  quotient;
    logic [divider_pkg::DIV_WIDTH-1:0]  remainder;
    logic                               div_end;

    modport master (
        output div_begin, div_signed, dividend, divisor,
        input  quotient, remainder, div_end
    );

    modport slave (
        input  div_begin, div_signed, dividend, divisor,
        output quotient, remainder, div_end
    );

endinterface

// File: rtl/div_restore_step.sv
// One restoring-division step: shift in a dividend bit, subtract divisor if it fits.
module div_restore_step
    import divider_pkg::*;
#(
    parameter int W = DIV_WIDTH
) (
    input  logic [W-1:0] rem,
    input  logic         next_bit,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] new_rem,
    output logic         q_bit
);

    logic [W:0] shifted_s;

    // The shifted remainder can need W+1 bits; the difference always fits in W when taken.
    always_comb begin
        shifted_s = {rem, next_bit};
        if (shifted_s >= {1'b0, divisor}) begin
            q_bit   = 1'b1;
            new_rem = shifted_s[W-1:0] - divisor;
        end else begin
            q_bit   = 1'b0;
            new_rem = shifted_s[W-1:0];
        end
    end

endmodule

// File: rtl/divider_32bit.sv
// Multi-cycle restoring divider, signed/unsigned, one quotient bit per clock.
module divider_32bit
    import divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic            clk,
    input  logic            resetn,
    divider_32bit_if.slave  bus
);

    localparam logic [DIV_CNT_W-1:0] LAST_STEP = 6'd31;
    localparam logic [DIV_CNT_W-1:0] CNT_ONE   = 6'd1;

    div_state_t             state_r;
    div_state_t             state_nxt_s;
    logic [DIV_CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]       dvd_r;
    logic [WIDTH-1:0]       rem_r;
    logic [WIDTH-1:0]       dsr_r;
    logic                   neg_q_r;
    logic                   neg_r_r;
    logic [WIDTH-1:0]       quotient_r;
    logic [WIDTH-1:0]       remainder_r;
    logic                   div_end_r;
    logic [WIDTH-1:0]       step_rem_s;
    logic                   step_q_s;

    div_restore_step #(.W(WIDTH)) u_step (
        .rem      (rem_r),
        .next_bit (dvd_r[WIDTH-1]),
        .divisor  (dsr_r),
        .new_rem  (step_rem_s),
        .q_bit    (step_q_s)
    );

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; dropping div_begin while busy abandons the operation.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.div_begin) state_nxt_s = CALC;
                else               state_nxt_s = IDLE;
            end
            CALC: begin
                if (!bus.div_begin)         state_nxt_s = IDLE;
                else if (cnt_r == LAST_STEP) state_nxt_s = FIX;
                else                        state_nxt_s = CALC;
            end
            FIX: begin
                if (!bus.div_begin) state_nxt_s = IDLE;
                else                state_nxt_s = DONE;
            end
            DONE: state_nxt_s = WAIT;
            WAIT: begin
                if (!bus.div_begin) state_nxt_s = IDLE;
                else                state_nxt_s = WAIT;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, sign fix-up and result registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_r       <= '0;
            dvd_r       <= '0;
            rem_r       <= '0;
            dsr_r       <= '0;
            neg_q_r     <= 1'b0;
            neg_r_r     <= 1'b0;
            quotient_r  <= '0;
            remainder_r <= '0;
            div_end_r   <= 1'b0;
        end else begin
            div_end_r <= (state_r == DONE);
            case (state_r)
                IDLE: begin
                    if (bus.div_begin) begin
                        cnt_r   <= '0;
                        rem_r   <= '0;
                        dvd_r   <= magnitude(bus.dividend, bus.div_signed);
                        dsr_r   <= magnitude(bus.divisor, bus.div_signed);
                        neg_q_r <= bus.div_signed & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
                        neg_r_r <= bus.div_signed & bus.dividend[WIDTH-1];
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                CALC: begin
                    rem_r <= step_rem_s;
                    dvd_r <= {dvd_r[WIDTH-2:0], step_q_s};
                    cnt_r <= cnt_r + CNT_ONE;
                end
                FIX: begin
                    if (bus.div_begin) begin
                        // Zero divisor reports all-ones regardless of operand signs.
                        if (dsr_r == '0)  quotient_r <= {WIDTH{1'b1}};
                        else if (neg_q_r) quotient_r <= twos_neg(dvd_r);
                        else              quotient_r <= dvd_r;
                        remainder_r <= neg_r_r ? twos_neg(rem_r) : rem_r;
                    end else begin
                        quotient_r <= quotient_r;
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    assign bus.quotient  = quotient_r;
    assign bus.remainder = remainder_r;
    assign bus.div_end   = div_end_r;

endmodule

// File: tb/tb_divider_32bit.sv
// Scoreboard bench for divider_32bit: latency, results, abort, hold and reset behaviour.
module tb_divider_32bit;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    divider_32bit_if bus();

    divider_32bit #(.WIDTH(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
    } exp_t;

    exp_t sb_q[$];
    int   passed = 0;
    int   total = 0;
    int   end_count = 0;

    always @(posedge clk) begin
        if (bus.div_end === 1'b1) end_count <= end_count + 1;
    end

    task automatic model(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         output exp_t e);
        if (b == 32'd0) begin
            e.q = 32'hFFFF_FFFF;
            e.r = a;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.q = 32'h8000_0000;
            e.r = 32'd0;
        end else if (sgn) begin
            e.q = $signed(a) / $signed(b);
            e.r = $signed(a) % $signed(b);
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
    endtask

    // Drives one operation, scrambles operands after the start edge, checks on div_end.
    task automatic run_op(input string name, input logic sgn,
                          input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   lat;
        bit   seen;
        model(sgn, a, b, e);
        sb_q.push_back(e);
        bus.div_signed = sgn;
        bus.dividend   = a;
        bus.divisor    = b;
        bus.div_begin  = 1'b1;
        @(posedge clk); #1;
        bus.dividend   = $urandom;
        bus.divisor    = $urandom;
        bus.div_signed = ~sgn;
        seen = 1'b0;
        lat  = 0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk); #1;
            if (bus.div_end === 1'b1) begin
                seen = 1'b1;
                lat  = i;
                break;
            end
        end
        total++;
        if (!seen) begin
            $display("FAIL %s timeout: no div_end within 60 cycles, required at 34", name);
            void'(sb_q.pop_front());
        end else begin
            if (lat !== 34) $display("FAIL %s latency: got %0d required 34", name, lat);
            else passed++;
            e = sb_q.pop_front();
            total++;
            if (bus.quotient !== e.q)
                $display("FAIL %s quotient: got %h required %h", name, bus.quotient, e.q);
            else passed++;
            total++;
            if (bus.remainder !== e.r)
                $display("FAIL %s remainder: got %h required %h", name, bus.remainder, e.r);
            else passed++;
            @(posedge clk); #1;
            total++;
            if (bus.div_end !== 1'b0)
                $display("FAIL %s pulse_width: div_end got %b required 0", name, bus.div_end);
            else passed++;
        end
        bus.div_begin = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        bus.div_begin  = 1'b0;
        bus.div_signed = 1'b0;
        bus.dividend   = 32'd0;
        bus.divisor    = 32'd0;
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (bus.quotient !== 32'd0) $display("FAIL reset_q: got %h required 0", bus.quotient);
        else passed++;
        total++;
        if (bus.remainder !== 32'd0) $display("FAIL reset_r: got %h required 0", bus.remainder);
        else passed++;
        total++;
        if (bus.div_end !== 1'b0) $display("FAIL reset_end: got %b required 0", bus.div_end);
        else passed++;
        resetn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        run_op("u100_7", 1'b0, 32'd100, 32'd7);
        run_op("u_max_2", 1'b0, 32'hFFFF_FFFF, 32'h0000_0002);
        run_op("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
        run_op("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE);
        run_op("u_big_div", 1'b0, 32'hF000_0001, 32'h8000_0003);
    endtask

    task automatic test_boundaries();
        run_op("u5_0", 1'b0, 32'd5, 32'd0);
        run_op("s_m5_0", 1'b1, 32'hFFFF_FFFB, 32'd0);
        run_op("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("u_small_big", 1'b0, 32'd3, 32'hFFFF_FFF0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++) begin
            run_op("rand", k[0], $urandom, $urandom_range(1, 32'h0001_FFFF));
        end
    endtask

    task automatic test_abort();
        int ec;
        run_op("abort_pre", 1'b0, 32'd100, 32'd7);
        bus.div_signed = 1'b0;
        bus.dividend   = 32'd50;
        bus.divisor    = 32'd3;
        bus.div_begin  = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        bus.div_begin = 1'b0;
        ec = end_count;
        repeat (50) @(posedge clk);
        #1;
        total++;
        if (end_count !== ec) $display("FAIL abort_end: got %0d pulses required 0", end_count - ec);
        else passed++;
        total++;
        if (bus.quotient !== 32'd14) $display("FAIL abort_q: got %h required %h", bus.quotient, 32'd14);
        else passed++;
        total++;
        if (bus.remainder !== 32'd2) $display("FAIL abort_r: got %h required %h", bus.remainder, 32'd2);
        else passed++;
        run_op("abort_post", 1'b0, 32'd50, 32'd3);
    endtask

    task automatic test_hold();
        exp_t e;
        int   pulses;
        int   first;
        model(1'b0, 32'd9, 32'd4, e);
        sb_q.push_back(e);
        bus.div_signed = 1'b0;
        bus.dividend   = 32'd9;
        bus.divisor    = 32'd4;
        bus.div_begin  = 1'b1;
        @(posedge clk); #1;
        pulses = 0;
        first  = 0;
        for (int i = 1; i <= 74; i++) begin
            @(posedge clk); #1;
            if (bus.div_end === 1'b1) begin
                pulses++;
                if (first == 0) first = i;
            end
        end
        total++;
        if (pulses !== 1) $display("FAIL hold_pulses: got %0d required 1", pulses);
        else passed++;
        total++;
        if (first !== 34) $display("FAIL hold_latency: got %0d required 34", first);
        else passed++;
        e = sb_q.pop_front();
        total++;
        if (bus.quotient !== e.q || bus.remainder !== e.r)
            $display("FAIL hold_result: got %h/%h required %h/%h",
                     bus.quotient, bus.remainder, e.q, e.r);
        else passed++;
        bus.div_begin = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int ec;
        bus.div_signed = 1'b0;
        bus.dividend   = 32'd1000;
        bus.divisor    = 32'd3;
        bus.div_begin  = 1'b1;
        repeat (10) @(posedge clk);
        #2;
        ec = end_count;
        resetn = 1'b0;
        #1;
        total++;
        if (bus.quotient !== 32'd0) $display("FAIL midrst_q: got %h required 0", bus.quotient);
        else passed++;
        total++;
        if (bus.remainder !== 32'd0) $display("FAIL midrst_r: got %h required 0", bus.remainder);
        else passed++;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (end_count !== ec) $display("FAIL midrst_end: got %0d pulses required 0", end_count - ec);
        else passed++;
        resetn = 1'b1;
        run_op("release_start", 1'b0, 32'd100, 32'd7);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_random();
        test_abort();
        test_hold();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/divider_32bit.md
DIVIDER_32BIT -- requirements
Module: divider_32bit

Interface
REQ-001 Parameter WIDTH SHALL default to 32 and set the operand/result width; only 32 is supported and verified.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 resetn  input  1  reset, asynchronous, active-low.
REQ-004 div_begin  input  1  level request; high starts/holds an operation, low aborts/re-arms.
REQ-005 div_signed  input  1  1 = two's-complement divide, 0 = unsigned; sampled with operands.
REQ-006 dividend  input  32  numerator; sampled at start.
REQ-007 divisor  input  32  denominator; sampled at start.
REQ-008 quotient  output  32  registered result.
REQ-009 remainder  output  32  registered result.
REQ-010 div_end  output  1  one-cycle pulse marking quotient/remainder valid.

Function
REQ-011 States SHALL be IDLE, CALC, FIX, DONE and WAIT.
REQ-012 IDLE with div_begin=1 at a rising edge: latch dividend, divisor and div_signed, then go to CALC with the iteration counter at 0.
REQ-013 Signed mode: operands latched as magnitudes; original signs kept for FIX.
REQ-014 CALC SHALL perform one restoring step per cycle, MSB first: shift the partial remainder left, bring in the next dividend bit, subtract the divisor magnitude if the result is non-negative, set the quotient bit, and run exactly 32 cycles (6-bit counter 0..31).
REQ-015 FIX, 1 cycle: negate the quotient if the signs differ (signed mode); negate the remainder if the dividend is negative (signed mode); register both outputs.
REQ-016 DONE, 1 cycle: div_end=1, then go to WAIT.
REQ-017 Latency: div_end SHALL be high in the cycle beginning 34 rising edges after the edge that sampled div_begin in IDLE.
REQ-018 WAIT: stay until div_begin=0, then go to IDLE; no restart without a low-high cycle on div_begin.
REQ-019 div_begin=0 in CALC or FIX: abort to IDLE, no div_end, quotient/remainder keep the last completed values.
REQ-020 Divide by zero (either mode): quotient=0xFFFFFFFF, remainder=dividend, same latency, div_end pulsed.
REQ-021 Signed overflow 0x80000000 / 0xFFFFFFFF: quotient=0x80000000, remainder=0.
REQ-022 Operand inputs changing after the start edge SHALL NOT affect the operation in progress.
REQ-023 Outputs SHALL change only in FIX, or on reset.

Reset
REQ-024 resetn=0 SHALL immediately force IDLE, counter=0, quotient=0, remainder=0, div_end=0, and clear all internal registers, including mid-operation.
REQ-025 Release with div_begin already high: start on the first rising edge after release.

Structure
REQ-026 Shared package divider_pkg SHALL hold the state enum typedef, DIV_WIDTH=32 and DIV_CNT_W=6.
REQ-027 Sub-module div_restore_step (combinational: partial remainder, next bit, divisor -> new remainder, quotient bit) SHALL be the only sub-module.

Verification
REQ-028 Unsigned 100/7 -> quotient=14, remainder=2, div_end 34 cycles after start, single cycle wide.
REQ-029 Unsigned 0xFFFFFFFF/0x00000002 -> quotient 0x7FFFFFFF, remainder 0x00000001; signed -7/2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
REQ-030 Zero divisor and overflow: 5/0 -> 0xFFFFFFFF/0x00000005; signed 0x80000000/0xFFFFFFFF -> 0x80000000/0.
REQ-031 Abort: complete 100/7, start 50/3, drop div_begin after 10 cycles -> no div_end, outputs stay 14/2; next start of 50/3 -> 16/2.
REQ-032 Hold div_begin high 40 cycles after completion -> exactly one div_end; resetn pulsed low mid-CALC -> outputs 0 immediately, no div_end.
